rdma_wr_data_gate: RTL and testbench

- Sits directly downstream of the RDMA network-side slice stage, on the user side of the write path.
- Consumes the write-request command stream (req_t) and the write-data AXI4S stream.
- Forwards each request to the user and releases that request's data only after the request has been handed off.
- Regenerates tlast from the request length, and polices and counts length/tlast mismatches so a malformed packet cannot desynchronise later requests.

---
 rtl/rdma_wr_data_gate_pkg.sv | 15 +
 rtl/rdma_wr_len_fifo.sv | 53 +++++
 rtl/rdma_wr_data_gate.sv | 189 ++++++++++++++++++
 tb/tb_rdma_wr_data_gate.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_wr_data_gate_pkg.sv
// Shared constants and types for the RDMA write-data gate.
package rdma_wr_data_gate_pkg;

  localparam int unsigned RDMA_WR_LEN_LSB  = 64;
  localparam int unsigned RDMA_WR_LEN_BITS = 28;
  localparam int unsigned NET_BEAT_BYTES   = 64;
  localparam int unsigned NET_BEAT_SHIFT   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } wr_gate_state_t;

endpackage

// File: rtl/rdma_wr_len_fifo.sv
// Synchronous FIFO of per-request beat counts.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data_c (head),
//        full_c, empty_c, count (occupancy 0..DEPTH).
module rdma_wr_len_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c     = (count == CW'(DEPTH));
  assign empty_c    = (count == '0);
  assign do_push    = push & ~full_c;
  assign do_pop     = pop & ~empty_c;
  assign pop_data_c = mem[rd_ptr];

  // Pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rdma_wr_data_gate.sv
// Gates RDMA write data behind its request: forwards each req_t to the user,
// releases the matching data only after the request has been handed off,
// regenerates tlast from the request length and counts length/tlast errors.
// Ports: aclk, aresetn (sync, active-high); s_req_*/m_req_* request pass-through;
//        s_axis_*/m_axis_* write data; err_short_cnt/err_long_cnt; pending.
module rdma_wr_data_gate
  import rdma_wr_data_gate_pkg::*;
#(
  parameter int unsigned N_OUTSTANDING = 16,
  parameter int unsigned REQ_LEN_LSB   = RDMA_WR_LEN_LSB,
  parameter int unsigned REQ_LEN_BITS  = RDMA_WR_LEN_BITS,
  parameter int unsigned DATA_BITS     = 512
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             s_req_valid,
  output logic                             s_req_ready,
  input  logic [127:0]                     s_req_data,
  output logic                             m_req_valid,
  input  logic                             m_req_ready,
  output logic [127:0]                     m_req_data,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic [DATA_BITS-1:0]             s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]           s_axis_tkeep,
  input  logic                             s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_BITS-1:0]             m_axis_tdata,
  output logic [DATA_BITS/8-1:0]           m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [31:0]                      err_short_cnt,
  output logic [31:0]                      err_long_cnt,
  output logic [$clog2(N_OUTSTANDING):0]   pending
);

  localparam int unsigned LEN_RW    = REQ_LEN_BITS + 1;
  localparam int unsigned BEAT_BITS = LEN_RW - NET_BEAT_SHIFT;
  localparam int unsigned KEEP_BITS = DATA_BITS / 8;
  localparam int unsigned ENT_BITS  = DATA_BITS + KEEP_BITS + 1;

  // Request path: combinational pass-through, stalled by a full FIFO or reset.
  logic                 req_open;
  logic                 req_push;
  logic [LEN_RW-1:0]    len_round;
  logic [BEAT_BITS-1:0] push_beats;
  logic [BEAT_BITS-1:0] head_beats;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  assign req_open    = ~aresetn & ~fifo_full;
  assign m_req_valid = s_req_valid & req_open;
  assign s_req_ready = m_req_ready & req_open;
  assign m_req_data  = s_req_data;
  assign req_push    = s_req_valid & m_req_ready & req_open;
  assign len_round   = {1'b0, s_req_data[REQ_LEN_LSB +: REQ_LEN_BITS]}
                     + LEN_RW'(NET_BEAT_BYTES - 1);
  assign push_beats  = len_round[LEN_RW-1:NET_BEAT_SHIFT];

  rdma_wr_len_fifo #(
    .DEPTH (N_OUTSTANDING),
    .WIDTH (BEAT_BITS)
  ) u_len_fifo (
    .clk        (aclk),
    .rst        (aresetn),
    .push       (req_push),
    .push_data  (push_beats),
    .pop        (fifo_pop),
    .pop_data_c (head_beats),
    .full_c     (fifo_full),
    .empty_c    (fifo_empty),
    .count      (pending)
  );

  // Two-entry skid buffer on the data output.
  logic [ENT_BITS-1:0] skid_mem [2];
  logic                skid_wr;
  logic                skid_rd;
  logic [1:0]          skid_cnt;
  logic                skid_space;
  logic                skid_push;
  logic                skid_pop;
  logic                skid_tlast;

  assign skid_space    = (skid_cnt != 2'd2);
  assign m_axis_tvalid = (skid_cnt != 2'd0);
  assign skid_pop      = m_axis_tvalid & m_axis_tready;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = skid_mem[skid_rd];

  always_ff @(posedge aclk) begin
    if (skid_push) skid_mem[skid_wr] <= {s_axis_tdata, s_axis_tkeep, skid_tlast};
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      skid_wr  <= 1'b0;
      skid_rd  <= 1'b0;
      skid_cnt <= 2'd0;
    end else begin
      if (skid_push) skid_wr <= ~skid_wr;
      if (skid_pop)  skid_rd <= ~skid_rd;
      if (skid_push && !skid_pop)      skid_cnt <= skid_cnt + 2'd1;
      else if (skid_pop && !skid_push) skid_cnt <= skid_cnt - 2'd1;
    end
  end

  // Packet FSM: state register.
  wr_gate_state_t       state_q, state_d;
  logic [BEAT_BITS-1:0] cnt_q, cnt_d;
  logic [BEAT_BITS-1:0] tgt_q, tgt_d;
  logic                 exp_last;
  logic                 short_inc;
  logic                 long_inc;

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  // Packet FSM: next state, data-path controls and error strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tgt_d         = tgt_q;
    fifo_pop      = 1'b0;
    s_axis_tready = 1'b0;
    skid_push     = 1'b0;
    skid_tlast    = 1'b0;
    short_inc     = 1'b0;
    long_inc      = 1'b0;
    exp_last      = (cnt_q == tgt_q - BEAT_BITS'(1));
    case (state_q)
      IDLE: begin
        // Zero-length entries are retired without touching the data stream.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_beats != '0) begin
            cnt_d   = '0;
            tgt_d   = head_beats;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        s_axis_tready = skid_space;
        if (s_axis_tvalid && skid_space) begin
          skid_push  = 1'b1;
          skid_tlast = exp_last | s_axis_tlast;
          if (s_axis_tlast) begin
            short_inc = ~exp_last;
            state_d   = IDLE;
          end else if (exp_last) begin
            long_inc = 1'b1;
            state_d  = DRAIN;
          end else begin
            cnt_d = cnt_q + BEAT_BITS'(1);
          end
        end
      end
      DRAIN: begin
        // Surplus beats of an over-long packet are swallowed up to its tlast.
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (aresetn) s_axis_tready = 1'b0;
  end

  // Saturating error counters.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      err_short_cnt <= '0;
      err_long_cnt  <= '0;
    end else begin
      if (short_inc && err_short_cnt != '1) err_short_cnt <= err_short_cnt + 32'd1;
      if (long_inc && err_long_cnt != '1)   err_long_cnt  <= err_long_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_rdma_wr_data_gate.sv
// Scoreboard bench for rdma_wr_data_gate: a packet-level reference model fills
// expected queues, independent monitors pop and compare on every handshake.
module tb_rdma_wr_data_gate;

  localparam int TMO = 3000;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         s_req_valid, s_req_ready;
  logic [127:0] s_req_data;
  logic         m_req_valid, m_req_ready;
  logic [127:0] m_req_data;
  logic         s_axis_tvalid, s_axis_tready;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic         m_axis_tvalid, m_axis_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [31:0]  err_short_cnt, err_long_cnt;
  logic [4:0]   pending;

  rdma_wr_data_gate dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .err_short_cnt(err_short_cnt), .err_long_cnt(err_long_cnt), .pending(pending)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  logic [127:0] req_q[$];
  beat_t        beat_q[$];
  logic [127:0] exp_req_q[$];
  beat_t        exp_beat_q[$];

  int compared = 0, mismatched = 0;
  int exp_short = 0, exp_long = 0;
  int ready_mode = 0;   // 0: all ready, 1: random, 2: req ready / data stalled
  int cyc = 0, first_in_cyc = -1, first_out_cyc = -1;
  bit fwd_check = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out after %0d cycles, required handshake", name, TMO);
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Sink readiness.
  initial forever begin
    @(posedge aclk);
    #1;
    case (ready_mode)
      0:       begin m_req_ready = 1'b1; m_axis_tready = 1'b1; end
      1:       begin m_req_ready = ($urandom_range(0, 3) != 0); m_axis_tready = ($urandom_range(0, 2) != 0); end
      default: begin m_req_ready = 1'b1; m_axis_tready = 1'b0; end
    endcase
  end

  // Monitors: sample mid-cycle, the handshake completes at the next edge.
  initial forever begin
    @(negedge aclk);
    if (m_req_valid && m_req_ready) begin
      compared++;
      if (exp_req_q.size() == 0) begin
        mismatched++;
        $display("FAIL req unexpected: got %h expected none", m_req_data);
      end else begin
        logic [127:0] e;
        e = exp_req_q.pop_front();
        if (m_req_data !== e) begin
          mismatched++;
          $display("FAIL req data: got %h expected %h", m_req_data, e);
        end
      end
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beat_t a;
      a = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (first_out_cyc < 0) first_out_cyc = cyc;
      compared++;
      if (exp_beat_q.size() == 0) begin
        mismatched++;
        $display("FAIL beat unexpected: got last=%0b data=%h expected none", a.last, a.data);
      end else begin
        beat_t e;
        e = exp_beat_q.pop_front();
        if (a !== e) begin
          mismatched++;
          $display("FAIL beat: got last=%0b keep=%h data=%h expected last=%0b keep=%h data=%h",
                   a.last, a.keep, a.data[127:0], e.last, e.keep, e.data[127:0]);
        end
      end
    end
    if (s_axis_tvalid && s_axis_tready && first_in_cyc < 0) first_in_cyc = cyc;
  end

  function automatic logic [127:0] mk_req(input int len);
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[91:64] = 28'(len);
    return r;
  endfunction

  // One request plus an upstream packet of nbeats beats, tlast on the final beat.
  task automatic add_pkt(input int len, input int nbeats);
    logic [127:0] r;
    r = mk_req(len);
    req_q.push_back(r);
    exp_req_q.push_back(r);
    for (int i = 0; i < nbeats; i++) begin
      beat_t b;
      for (int j = 0; j < 16; j++) b.data[j*32 +: 32] = $urandom;
      b.keep = {$urandom, $urandom};
      b.last = (i == nbeats - 1);
      beat_q.push_back(b);
    end
  endtask

  // Reference: each request of n = ceil(len/64) beats owns input beats up to the
  // next upstream tlast; the first n are forwarded, tlast forced on beat n-1.
  task automatic model_run();
    int bi = 0;
    foreach (req_q[r]) begin
      int n;
      n = (int'(req_q[r][91:64]) + 63) / 64;
      if (n > 0) begin
        for (int k = 0; bi < beat_q.size(); k++) begin
          beat_t b;
          b = beat_q[bi];
          bi++;
          if (k < n) begin
            beat_t e;
            e = b;
            e.last = b.last || (k == n - 1);
            exp_beat_q.push_back(e);
          end
          if (b.last && k < n - 1) exp_short++;
          if (!b.last && k == n - 1) exp_long++;
          if (b.last) break;
        end
      end
    end
  endtask

  // Drivers: entered at posedge+1, hold valid until ready is seen mid-cycle.
  task automatic send_req(input logic [127:0] r);
    int t = 0;
    s_req_valid = 1'b1;
    s_req_data  = r;
    forever begin
      @(negedge aclk);
      if (fwd_check) begin
        fwd_check = 1'b0;
        check("req forwarded same cycle", m_req_valid, 1);
      end
      if (s_req_ready) break;
      if (++t > TMO) begin timeout_fail("s_req handshake"); break; end
    end
    @(posedge aclk);
    #1;
    s_req_valid = 1'b0;
  endtask

  task automatic send_beat(input beat_t b);
    int t = 0;
    s_axis_tvalid = 1'b1;
    {s_axis_tdata, s_axis_tkeep, s_axis_tlast} = b;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      if (++t > TMO) begin timeout_fail("s_axis handshake"); break; end
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drive_reqs(input bit gaps);
    while (req_q.size() != 0) begin
      send_req(req_q.pop_front());
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    end
  endtask

  task automatic drive_beats(input bit gaps);
    while (beat_q.size() != 0) begin
      send_beat(beat_q.pop_front());
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_beat_q.size() != 0 || exp_req_q.size() != 0) begin
      @(negedge aclk);
      if (++t > TMO) begin
        timeout_fail({name, " drain"});
        exp_beat_q.delete();
        exp_req_q.delete();
        break;
      end
    end
    repeat (4) @(negedge aclk);
    check({name, " err_short_cnt"}, err_short_cnt, exp_short);
    check({name, " err_long_cnt"}, err_long_cnt, exp_long);
    check({name, " pending"}, pending, 0);
    check({name, " m_axis_tvalid idle"}, m_axis_tvalid, 0);
    @(posedge aclk);
    #1;
  endtask

  // hold > 0: data is offered for that many cycles before any request.
  task automatic run_scenario(input string name, input bit gaps, input int hold);
    fork
      drive_beats(gaps);
      begin
        for (int i = 0; i < hold; i++) begin
          @(negedge aclk);
          check({name, " tready before req"}, s_axis_tready, 0);
        end
        if (hold > 0) begin @(posedge aclk); #1; end
        drive_reqs(gaps);
      end
    join
    wait_drain(name);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_req_valid = 1'b0; s_req_data = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    m_req_ready = 1'b0; m_axis_tready = 1'b0;
    aresetn = 1'b1;

    // Reset: request offered with a ready sink must still be blocked.
    s_req_valid = 1'b1;
    s_req_data  = mk_req(64);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset m_req_valid", m_req_valid, 0);
    check("reset s_req_ready", s_req_ready, 0);
    check("reset s_axis_tready", s_axis_tready, 0);
    check("reset m_axis_tvalid", m_axis_tvalid, 0);
    @(posedge aclk);
    #1;
    s_req_valid = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    check("post-reset pending", pending, 0);
    check("post-reset err_short_cnt", err_short_cnt, 0);
    check("post-reset err_long_cnt", err_long_cnt, 0);
    @(posedge aclk);
    #1;

    // len=256, four beats, always ready: same-cycle forward, 1-cycle data latency.
    add_pkt(256, 4);
    model_run();
    first_in_cyc = -1;
    first_out_cyc = -1;
    fwd_check = 1'b1;
    run_scenario("basic", 1'b0, 0);
    check("first beat latency", 64'(first_out_cyc - first_in_cyc), 1);

    // Data offered ahead of its request; len=65 gives two beats.
    add_pkt(65, 2);
    model_run();
    run_scenario("data first", 1'b0, 8);

    // Short packet (5 expected, tlast on 3rd), then a clean len=64.
    add_pkt(320, 3);
    add_pkt(64, 1);
    model_run();
    run_scenario("short", 1'b0, 0);

    // Long packet: 2 expected, 4 sent; last two are dropped.
    add_pkt(128, 4);
    model_run();
    run_scenario("long", 1'b0, 0);

    // len=0 consumes nothing; the single beat belongs to the len=64 request.
    add_pkt(0, 0);
    add_pkt(64, 1);
    model_run();
    run_scenario("zero len", 1'b0, 0);

    // Fill: data stalled, the first request is already popped into STREAM,
    // so 17 are accepted before the FIFO reports 16 and closes.
    ready_mode = 2;
    for (int i = 0; i < 18; i++) begin
      int len, n;
      len = $urandom_range(1, 300);
      n = (len + 63) / 64;
      add_pkt(len, n);
    end
    model_run();
    @(posedge aclk);
    #1;
    for (int i = 0; i < 17; i++) send_req(req_q.pop_front());
    s_req_valid = 1'b1;
    s_req_data  = req_q[0];
    repeat (3) begin
      @(negedge aclk);
      check("full pending", pending, 16);
      check("full s_req_ready", s_req_ready, 0);
    end
    @(posedge aclk);
    #1;
    ready_mode = 1;
    run_scenario("fill drain", 1'b1, 0);

    // Random mix of lengths, short/long/exact packets, random backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      ready_mode = (pass == 0) ? 1 : 0;
      for (int i = 0; i < 30; i++) begin
        int len, n, p;
        len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 700);
        n = (len + 63) / 64;
        p = n;
        if (n > 0) begin
          case ($urandom_range(0, 3))
            0: if (n > 1) p = $urandom_range(1, n - 1);
            1: p = n + $urandom_range(1, 3);
            default: p = n;
          endcase
        end
        add_pkt(len, p);
      end
      model_run();
      run_scenario((pass == 0) ? "random stall" : "random flow", pass == 0, 0);
    end

    // Reset mid-STREAM with two beats parked in the skid buffer.
    ready_mode = 2;
    @(posedge aclk);
    #1;
    begin
      logic [127:0] r;
      beat_t b;
      r = mk_req(256);
      exp_req_q.push_back(r);
      send_req(r);
      r = mk_req(64);
      exp_req_q.push_back(r);
      send_req(r);
      for (int i = 0; i < 2; i++) begin
        b = {{16{32'h5a5a_0000 + 32'(i)}}, 64'hffff_ffff_ffff_ffff, 1'b0};
        send_beat(b);
      end
    end
    @(negedge aclk);
    check("pre-reset m_axis_tvalid", m_axis_tvalid, 1);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    exp_short = 0;
    exp_long = 0;
    @(negedge aclk);
    check("mid reset m_axis_tvalid", m_axis_tvalid, 0);
    check("mid reset pending", pending, 0);
    check("mid reset s_axis_tready", s_axis_tready, 0);
    @(posedge aclk);
    #1;
    ready_mode = 0;
    add_pkt(64, 1);
    model_run();
    run_scenario("after reset", 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
